// File: rtl/game_timer_pkg.sv
// rtl/game_timer_pkg.sv - shared types and constants for the game countdown timer
package game_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [3:0] bcd_t;

    // Largest displayable value, 99:59, in packed BCD
    localparam logic [7:0] MAX_MM = 8'h99;
    localparam logic [7:0] MAX_SS = 8'h59;

endpackage

// File: rtl/bcd_mmss_adjust.sv
// rtl/bcd_mmss_adjust.sv - combinational mm:ss BCD add/decrement with clamping at 00:00 and 99:59
module bcd_mmss_adjust
    import game_timer_pkg::*;
(
    input  bcd_t       d3_i,
    input  bcd_t       d2_i,
    input  bcd_t       d1_i,
    input  bcd_t       d0_i,
    input  logic       dec_i,
    input  logic [3:0] add_i,
    output bcd_t       q3_o,
    output bcd_t       q2_o,
    output bcd_t       q1_o,
    output bcd_t       q0_o,
    output logic       is_zero_o
);

    logic [6:0] mins;
    logic [6:0] mins_n;
    logic [6:0] secs_n;
    logic [7:0] secs_sum;
    logic [7:0] secs_t;
    logic       sat;

    // Work in binary minutes/seconds so add and decrement resolve in one pass,
    // then split back into BCD digits; 00:00 never wraps below zero
    always_comb begin
        mins     = 7'(d3_i) * 7'd10 + 7'(d2_i);
        secs_sum = 8'(d1_i) * 8'd10 + 8'(d0_i) + 8'(add_i);
        secs_t   = secs_sum;
        mins_n   = mins;
        secs_n   = 7'(secs_sum);
        sat      = 1'b0;
        if (dec_i && (secs_sum == 8'd0)) begin
            if (mins == 7'd0) begin
                mins_n = 7'd0;
                secs_n = 7'd0;
            end else begin
                mins_n = mins - 7'd1;
                secs_n = 7'd59;
            end
        end else begin
            secs_t = secs_sum - 8'(dec_i);
            if (secs_t >= 8'd60) begin
                if (mins >= 7'd99) begin
                    sat = 1'b1;
                end else begin
                    mins_n = mins + 7'd1;
                    secs_n = 7'(secs_t - 8'd60);
                end
            end else begin
                secs_n = 7'(secs_t);
            end
        end

        if (sat) begin
            q3_o = MAX_MM[7:4];
            q2_o = MAX_MM[3:0];
            q1_o = MAX_SS[7:4];
            q0_o = MAX_SS[3:0];
        end else begin
            q3_o = 4'(mins_n / 7'd10);
            q2_o = 4'(mins_n % 7'd10);
            q1_o = 4'(secs_n / 7'd10);
            q0_o = 4'(secs_n % 7'd10);
        end
        is_zero_o = !sat && (mins_n == 7'd0) && (secs_n == 7'd0);
    end

endmodule

// File: rtl/game_countdown_timer.sv
// rtl/game_countdown_timer.sv - BCD mm:ss round clock with start/pause/bonus; warn output under GAME_TIMER_WARN_EN
module game_countdown_timer
    import game_timer_pkg::*;
#(
    parameter int         TICK_DIV = 50_000_000,
    parameter logic [7:0] START_MM = 8'h02,
    parameter logic [7:0] START_SS = 8'h00,
    parameter int         BONUS_S  = 5
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       pause,
    input  logic       bonus,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       running,
    output logic       expired
`ifdef GAME_TIMER_WARN_EN
    ,
    output logic       warn
`endif
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    bcd_t          d3_q, d2_q, d1_q, d0_q;
    bcd_t          d3_d, d2_d, d1_d, d0_d;
    logic          running_q, running_d;
    logic          expired_q, expired_d;

    logic          active;
    logic          tick;
    bcd_t          a3, a2, a1, a0;
    logic          a_zero;

    // The divider only advances when a counting state will not be holding
    // after this edge, so K paused cycles shift the next tick by exactly K
    assign active = ((state_q == ST_RUN) || (state_q == ST_PAUSE)) && !pause;
    assign tick   = active && (cnt_q == CW'(TICK_DIV - 1));

    bcd_mmss_adjust u_adjust (
        .d3_i      (d3_q),
        .d2_i      (d2_q),
        .d1_i      (d1_q),
        .d0_i      (d0_q),
        .dec_i     (tick),
        .add_i     (bonus ? 4'(BONUS_S) : 4'd0),
        .q3_o      (a3),
        .q2_o      (a2),
        .q1_o      (a1),
        .q0_o      (a0),
        .is_zero_o (a_zero)
    );

    // Next-state, divider and digit update; start overrides everything
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        d3_d      = d3_q;
        d2_d      = d2_q;
        d1_d      = d1_q;
        d0_d      = d0_q;
        expired_d = 1'b0;
        if (start) begin
            d3_d    = START_MM[7:4];
            d2_d    = START_MM[3:0];
            d1_d    = START_SS[7:4];
            d0_d    = START_SS[3:0];
            cnt_d   = '0;
            state_d = pause ? ST_PAUSE : ST_RUN;
        end else begin
            case (state_q)
                ST_RUN, ST_PAUSE: begin
                    if (active) begin
                        cnt_d = tick ? '0 : cnt_q + CW'(1);
                    end
                    state_d = pause ? ST_PAUSE : ST_RUN;
                    if (tick || bonus) begin
                        d3_d = a3;
                        d2_d = a2;
                        d1_d = a1;
                        d0_d = a0;
                        if (a_zero) begin
                            state_d   = ST_DONE;
                            expired_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        running_d = (state_d == ST_RUN);
    end

    // State, divider and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            d3_q      <= START_MM[7:4];
            d2_q      <= START_MM[3:0];
            d1_q      <= START_SS[7:4];
            d0_q      <= START_SS[3:0];
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d3_q      <= d3_d;
            d2_q      <= d2_d;
            d1_q      <= d1_d;
            d0_q      <= d0_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

    assign digit3  = d3_q;
    assign digit2  = d2_q;
    assign digit1  = d1_q;
    assign digit0  = d0_q;
    assign running = running_q;
    assign expired = expired_q;

`ifdef GAME_TIMER_WARN_EN
    logic warn_q;
    logic warn_d;

    // Last ten seconds of an active round: 00:00..00:10
    always_comb begin
        warn_d = ((state_d == ST_RUN) || (state_d == ST_PAUSE)) &&
                 (d3_d == 4'd0) && (d2_d == 4'd0) &&
                 ((d1_d == 4'd0) || ((d1_d == 4'd1) && (d0_d == 4'd0)));
    end

    // Registered warning flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= warn_d;
        end
    end

    assign warn = warn_q;
`endif

endmodule
